// File: rtl/fp_fcl_stream.sv
// fp_fcl_stream: streaming fixed-point FC engine; start/len/shift/relu_en/bias set a job, in_valid/in_ready carry INPUT+W beats, out_valid/out_ready carry OUTPUT+ovf, busy flags non-IDLE
module fp_fcl_stream #(
  parameter int DATAWIDTH    = 8,
  parameter int PARALLEL_NUM = 4,
  parameter int ACCWIDTH     = 24,
  parameter int OUTWIDTH     = 8,
  parameter int LENWIDTH     = 10
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [LENWIDTH-1:0]                           len,
  input  logic [4:0]                                    shift,
  input  logic                                          relu_en,
  input  logic [PARALLEL_NUM-1:0][ACCWIDTH-1:0]         bias,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic signed [DATAWIDTH-1:0]                   INPUT,
  input  logic [PARALLEL_NUM-1:0][DATAWIDTH-1:0]        W,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [PARALLEL_NUM-1:0][OUTWIDTH-1:0]         OUTPUT,
  output logic                                          ovf,
  output logic                                          busy
);
  localparam int SW = ACCWIDTH + 1;
  localparam logic [4:0] SMAX = 5'(ACCWIDTH - 1);
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** (OUTWIDTH - 1)) - 1);
  localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (OUTWIDTH - 1)));
  typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;
  state_t state, nxt;
  logic [LENWIDTH-1:0] len_r, cnt;
  logic [4:0] shift_r, s;
  logic relu_r, ovf_r;
  logic signed [ACCWIDTH-1:0] acc [PARALLEL_NUM];
  logic signed [2*DATAWIDTH-1:0] prod [PARALLEL_NUM];
  logic [PARALLEL_NUM-1:0][OUTWIDTH-1:0] sat, out_r;
  logic [PARALLEL_NUM-1:0] clip;
  logic signed [SW-1:0] rnd;
  logic last;
  assign last = cnt == len_r - LENWIDTH'(1);
  assign s = shift_r > SMAX ? SMAX : shift_r;
  assign rnd = s == 5'd0 ? '0 : SW'(1) << (s - 5'd1);
  // rounding add is done one bit wider than the accumulator so it cannot wrap
  for (genvar i = 0; i < PARALLEL_NUM; i++) begin : g_lane
    logic signed [SW-1:0] sum, r, q;
    assign prod[i] = INPUT * $signed(W[i]);
    assign sum = $signed({acc[i][ACCWIDTH-1], acc[i]}) + rnd;
    assign r = sum >>> s;
    assign q = relu_r && r < 0 ? '0 : r;
    assign clip[i] = q > MAXV || q < MINV;
    assign sat[i] = q > MAXV ? MAXV[OUTWIDTH-1:0] : q < MINV ? MINV[OUTWIDTH-1:0] : q[OUTWIDTH-1:0];
  end
  always_comb begin
    nxt = state == IDLE ? (start ? (len != '0 ? ACC : FIN) : IDLE) :
          state == ACC  ? (in_valid && last ? FIN : ACC) :
          state == FIN  ? OUT : (out_ready ? IDLE : OUT);
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      len_r <= '0;
      cnt <= '0;
      shift_r <= '0;
      relu_r <= 1'b0;
      out_r <= '0;
      ovf_r <= 1'b0;
      for (int i = 0; i < PARALLEL_NUM; i++) acc[i] <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_r <= len;
        shift_r <= shift;
        relu_r <= relu_en;
        cnt <= '0;
        for (int i = 0; i < PARALLEL_NUM; i++) acc[i] <= $signed(bias[i]);
      end
      if (state == ACC && in_valid) begin
        cnt <= cnt + LENWIDTH'(1);
        for (int i = 0; i < PARALLEL_NUM; i++) acc[i] <= acc[i] + ACCWIDTH'(prod[i]);
      end
      if (state == FIN) begin
        out_r <= sat;
        ovf_r <= |clip;
      end
    end
  end
  assign in_ready = state == ACC;
  assign out_valid = state == OUT;
  assign busy = state != IDLE;
  assign OUTPUT = out_r;
  assign ovf = ovf_r;
endmodule

// File: tb/tb_fp_fcl_stream.sv
// tb_fp_fcl_stream: directed vector bench for fp_fcl_stream plus an ACCWIDTH=16 instance for the wrap case
module tb_fp_fcl_stream;
  logic clk = 1'b0;
  logic rst, start, relu_en, in_valid, in_ready, out_valid, out_ready, ovf, busy;
  logic [9:0] len;
  logic [4:0] shift;
  logic [3:0][23:0] bias;
  logic [3:0][15:0] bias16;
  logic signed [7:0] x;
  logic [3:0][7:0] w, o, o16;
  logic in_ready16, out_valid16, ovf16, busy16;
  int checks = 0, failures = 0;
  typedef struct {int n, sh, rl; int b[4]; int xb, xs; int w[4]; int e[4]; int eo;} vec_t;
  vec_t v[6];
  always #5 clk = ~clk;
  fp_fcl_stream dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .shift(shift), .relu_en(relu_en),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .INPUT(x), .W(w),
    .out_valid(out_valid), .out_ready(out_ready), .OUTPUT(o), .ovf(ovf), .busy(busy)
  );
  fp_fcl_stream #(.ACCWIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .len(len), .shift(shift), .relu_en(relu_en),
    .bias(bias16), .in_valid(in_valid), .in_ready(in_ready16), .INPUT(x), .W(w),
    .out_valid(out_valid16), .out_ready(out_ready), .OUTPUT(o16), .ovf(ovf16), .busy(busy16)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t t, input string nm);
    @(negedge clk);
    len = 10'(t.n);
    shift = 5'(t.sh);
    relu_en = t.rl[0];
    for (int i = 0; i < 4; i++) bias[i] = 24'(t.b[i]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, ".busy"}, busy, 1);
    for (int k = 0; k < t.n; k++) begin
      chk({nm, ".in_ready"}, in_ready, 1);
      x = 8'(t.xb + k * t.xs);
      for (int i = 0; i < 4; i++) w[i] = 8'(t.w[i]);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({nm, ".early_valid"}, out_valid, 0);
    @(negedge clk);
    chk({nm, ".out_valid"}, out_valid, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("%s.lane%0d", nm, i), $signed(o[i]), t.e[i]);
    chk({nm, ".ovf"}, ovf, t.eo);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, ".idle_busy"}, busy, 0);
    chk({nm, ".idle_valid"}, out_valid, 0);
  endtask
  initial begin
    vec_t t;
    v[0] = '{3, 0, 0, '{0, 0, 0, 0}, 1, 1, '{1, -1, 2, 0}, '{6, -6, 12, 0}, 0};
    v[1] = '{4, 0, 0, '{0, 0, 0, 0}, 127, 0, '{127, -128, 1, 0}, '{127, -128, 127, 0}, 1};
    v[2] = '{0, 1, 0, '{5, -5, 6, -6}, 0, 0, '{0, 0, 0, 0}, '{3, -2, 3, -3}, 0};
    v[3] = '{0, 0, 1, '{-6, 7, 0, -1}, 0, 0, '{0, 0, 0, 0}, '{0, 7, 0, 0}, 0};
    v[4] = '{2, 2, 1, '{0, 0, 0, 0}, -3, 0, '{10, -10, 5, 1}, '{0, 15, 0, 0}, 0};
    v[5] = '{0, 31, 0, '{4194304, -4194305, 8388607, -8388608}, 0, 0, '{0, 0, 0, 0}, '{1, -1, 1, -1}, 0};
    rst = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; shift = '0; bias = '0; bias16 = '0; x = '0; w = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 0);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.out", int'(o), 0);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) apply(v[n], $sformatf("vec%0d", n));
    // stalled input beats, output backpressure, ignored start/in_valid
    @(negedge clk);
    len = 10'd4; shift = '0; relu_en = 1'b0; bias = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w[0] = 8'd1; w[1] = 8'd2; w[2] = 8'd3; w[3] = 8'(-1);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      x = 8'(k + 1);
      @(negedge clk);
      in_valid = 1'b0;
      x = 8'd100;
      if (k < 3) @(negedge clk);
    end
    in_valid = 1'b1;
    chk("hs.early_valid", out_valid, 0);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk("hs.hold_valid", out_valid, 1);
      chk("hs.hold_in_ready", in_ready, 0);
      chk("hs.lane0", $signed(o[0]), 10);
      chk("hs.lane1", $signed(o[1]), 20);
      chk("hs.lane2", $signed(o[2]), 30);
      chk("hs.lane3", $signed(o[3]), -10);
      start = 1'b1;
      len = 10'd1;
      @(negedge clk);
    end
    start = 1'b0;
    in_valid = 1'b0;
    chk("hs.still_valid", out_valid, 1);
    chk("hs.ovf", ovf, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs.idle_busy", busy, 0);
    chk("hs.idle_valid", out_valid, 0);
    @(negedge clk);
    chk("hs.no_restart", busy, 0);
    // reset in the middle of accumulation
    len = 10'd5; bias = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = {4{8'd9}};
    x = 8'd9;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst.busy", busy, 0);
    chk("mid_rst.in_ready", in_ready, 0);
    chk("mid_rst.out_valid", out_valid, 0);
    chk("mid_rst.ovf", ovf, 0);
    chk("mid_rst.out", int'(o), 0);
    t = '{1, 0, 0, '{0, 0, 0, 0}, 2, 0, '{3, 3, 3, 3}, '{6, 6, 6, 6}, 0};
    apply(t, "fresh");
    // 16-bit accumulator wraps past +32767
    bias16 = '0;
    bias16[0] = 16'd32767;
    t = '{1, 0, 0, '{0, 0, 0, 0}, 1, 0, '{1, 0, 0, 0}, '{1, 0, 0, 0}, 0};
    apply(t, "wrap_main");
    chk("wrap16.lane0", $signed(o16[0]), -128);
    chk("wrap16.lane1", $signed(o16[1]), 0);
    chk("wrap16.ovf", ovf16, 1);
    chk("wrap16.busy", busy16, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
